// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: registers the ALU result with its control bundle, resolves the branch
// outcome from the ALU flags, and hands bundles downstream through a 2-entry skid buffer.
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] Result,
  input  logic            Zero,
  input  logic            Negative,
  input  logic            OverFlow,
  input  logic            Carry,
  input  logic            Branch,
  input  logic [2:0]      Funct3,
  input  logic            RegWrite,
  input  logic            MemWrite,
  input  logic [1:0]      ResultSrc,
  input  logic [XLEN-1:0] WriteData,
  input  logic [RW-1:0]   RD,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [RW-1:0]   RDM,
  output logic            BranchTakenM
);

  localparam int BW = 2 * XLEN + RW + 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, next_state;
  logic          branch_cond, branch_taken;
  logic          in_xfer, out_xfer;
  logic          load_main_in, load_main_skid, load_skid;
  logic [BW-1:0] in_bundle, main_q, skid_q;

  always_comb begin
    branch_cond = 1'b0;
    case (Funct3)
      3'b000:  branch_cond = Zero;
      3'b001:  branch_cond = ~Zero;
      3'b100:  branch_cond = Negative ^ OverFlow;
      3'b101:  branch_cond = ~(Negative ^ OverFlow);
      3'b110:  branch_cond = ~Carry;
      3'b111:  branch_cond = Carry;
      default: branch_cond = 1'b0;
    endcase
  end

  assign branch_taken = Branch & branch_cond;
  assign in_bundle    = {Result, WriteData, RegWrite, MemWrite, ResultSrc, RD, branch_taken};
  assign {ResultM, WriteDataM, RegWriteM, MemWriteM, ResultSrcM, RDM, BranchTakenM} = main_q;

  // Handshake outputs decode only the state register, keeping ready/valid free of combinational paths.
  assign in_ready  = (state == EMPTY) || (state == ONE);
  assign out_valid = (state == ONE) || (state == FULL);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            next_state   = ONE;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            load_skid  = 1'b1;
            next_state = FULL;
          end else if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (out_xfer) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            load_main_skid = 1'b1;
            next_state     = ONE;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= next_state;
      if (load_main_in) begin
        main_q <= in_bundle;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_bundle;
      end
    end
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage that sits directly downstream of the ALU. It captures the ALU result and flags together with the control and data bundle of the same instruction, and resolves the conditional-branch outcome from the flags. It presents the registered bundle to the memory stage through a valid/ready handshake, backed by a 2-entry skid buffer so that back-pressure never creates a combinational ready path.

## Interface
Parameters:
- XLEN, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset: one clock, asynchronous, active-low.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream bundle is valid.
- in_ready  output  1  stage can accept a bundle.
- Result  input  XLEN  ALU result.
- Zero, Negative, OverFlow, Carry  input  1 each  ALU flags.
- Branch  input  1  instruction is a conditional branch.
- Funct3  input  3  branch condition select.
- RegWrite, MemWrite  input  1 each  control bits.
- ResultSrc  input  2  writeback source select.
- WriteData  input  XLEN  store data.
- RD  input  RW  destination register.
- out_valid  output  1  output bundle is valid.
- out_ready  input  1  downstream accepts the bundle.
- ResultM, WriteDataM  output  XLEN  registered Result and WriteData.
- RegWriteM, MemWriteM  output  1 each  registered control bits.
- ResultSrcM  output  2  registered ResultSrc.
- RDM  output  RW  registered RD.
- BranchTakenM  output  1  registered branch decision.

## Operation
Branch decision, computed combinationally at the input and stored with the bundle. It is Branch AND cond, where cond is selected by Funct3:
- 000 beq: Zero.
- 001 bne: ~Zero.
- 100 blt: Negative ^ OverFlow.
- 101 bge: ~(Negative ^ OverFlow).
- 110 bltu: ~Carry.
- 111 bgeu: Carry.
- 010, 011: 0.

Transfers:
- Input transfer (IN) occurs when in_valid & in_ready.
- Output transfer (OUT) occurs when out_valid & out_ready.

Storage:
- Main register drives all *M outputs.
- Skid register holds one overflow bundle.

State machine:
- EMPTY: out_valid=0, in_ready=1.
  - IN: load main, go to ONE.
- ONE: out_valid=1, in_ready=1.
  - IN & ~OUT: load skid, go to FULL.
  - IN & OUT: load main with the new bundle, stay in ONE.
  - ~IN & OUT: go to EMPTY.
  - Otherwise: hold.
- FULL: out_valid=1, in_ready=0.
  - OUT: move skid into main, go to ONE.
  - Otherwise: hold.
- Unused state encoding: go to EMPTY.

Control and ordering rules:
- in_ready and out_valid are pure decodes of the state register and never depend on in_valid or out_ready in the same cycle.
- Bundles leave in strict arrival order; none is duplicated or dropped unless flush is asserted.
- flush has priority over every transition and sends the state to EMPTY next cycle. A bundle presented during the flush cycle is discarded, even though in_ready is high.
- Data registers are don't-care while their entry is invalid, except at reset.
- While out_valid=1 and OUT has not occurred, all *M outputs hold stable.

## Timing
- Latency: a bundle accepted at edge N appears on the outputs after edge N, and out_valid is high in cycle N+1, when the stage was EMPTY (or in ONE with a simultaneous OUT).
- Throughput: 1 bundle/cycle while out_ready=1.
- in_ready drops in the cycle after the transition to FULL and rises in the cycle after the FULL→ONE transition.
- Reset (rst=0, asynchronous, active mid-operation): state=EMPTY and in_ready=1. out_valid, ResultM, WriteDataM, RegWriteM, MemWriteM, ResultSrcM, RDM and BranchTakenM are all 0, and the skid register is 0.
- Reset release: the first transfer is possible at the first rising edge with rst=1.
- Flush: outputs go invalid in the cycle after the flush edge; data value is don't-care.

## Test plan
- Reset and pass-through: assert rst mid-stream and check all outputs are 0 with in_ready=1. Then send Result=0x0000_1234, RD=5, RegWrite=1 with out_ready=1; out_valid=1 next cycle with ResultM=0x1234 and RDM=5.
- Branch decode: apply each Funct3 with Branch=1 and flags Z/N/V/C=0/1/0/0, expecting BranchTakenM blt=1, bge=0, beq=0, bne=1, bltu=1, bgeu=0. With Branch=0 every case gives 0; Funct3=010 gives 0.
- Back-pressure: hold out_ready=0 and send A=0x1, B=0x2. The stage reaches FULL, in_ready=0, and C is held off. Release out_ready and A, B, C emerge in order on consecutive cycles.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with values 0..7. Output is 0..7 back-to-back and in_ready stays 1.
- Flush: with FULL state plus a valid input, pulse flush. Next cycle out_valid=0 and in_ready=1; no flushed bundle ever appears.
- Random: random in_valid/out_ready against a scoreboard for ≥10k cycles. There is no loss, duplication or reorder, and the *M outputs are stable whenever out_valid=1 and out_ready=0.
